// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with registered sync,
// blank, start-of-frame and end-of-line strobes plus a frame counter.
// Every output is decoded from the next-state counter values, so the strobes
// line up with the DrawX/DrawY presented in the same cycle.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       pix_ce,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       sof,
  output logic       eol,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       blank_q, blank_d;
  logic       sof_q, sof_d;
  logic       eol_q, eol_d;
  logic [7:0] fc_q, fc_d;
  logic       h_wrap, f_wrap;

  // Next-state counters and the output decode taken from those next values.
  // With pix_ce low the counters hold, so the level outputs hold too and
  // the one-cycle strobes drop to zero.
  always_comb begin
    h_wrap = pix_ce && (x_q == H_MAX);
    f_wrap = h_wrap && (y_q == V_MAX);
    x_d    = x_q;
    y_d    = y_q;
    if (pix_ce) x_d = h_wrap ? 10'd0 : x_q + 10'd1;
    if (h_wrap) y_d = (y_q == V_MAX) ? 10'd0 : y_q + 10'd1;
    hs_d    = !((x_d >= HS_START) && (x_d < HS_END));
    vs_d    = !((y_d >= VS_START) && (y_d < VS_END));
    blank_d = (x_d < H_VIS) && (y_d < V_VIS);
    eol_d   = pix_ce && (x_d == H_MAX);
    sof_d   = f_wrap;
    fc_d    = fc_q + {7'd0, f_wrap};
  end

  // State and output registers; reset parks the raster at (0,0) with no strobes.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b1;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      fc_q    <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      fc_q    <= fc_d;
    end
  end

  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign blank       = blank_q;
  assign sof         = sof_q;
  assign eol         = eol_q;
  assign frame_count = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a default-timing instance for line-level checks and a
// shrunken-timing instance (15x8 raster, 120 advances per frame) so whole
// frames, pix_ce gating, frame-counter wrap and async reset fit in a short run.
module tb_vga_timing_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pix_ce = 1'b1;

  logic [9:0] d_x, d_y;
  logic       d_hs, d_vs, d_blank, d_sof, d_eol;
  logic [7:0] d_fc;

  logic [9:0] s_x, s_y;
  logic       s_hs, s_vs, s_blank, s_sof, s_eol;
  logic [7:0] s_fc;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vga_timing_gen u_dflt (
    .vga_clk(clk), .reset(reset), .pix_ce(pix_ce),
    .DrawX(d_x), .DrawY(d_y), .hs(d_hs), .vs(d_vs), .blank(d_blank),
    .sof(d_sof), .eol(d_eol), .frame_count(d_fc)
  );

  // hs low on x 10..12, vs low on y 5..6, visible 8x4
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) u_small (
    .vga_clk(clk), .reset(reset), .pix_ce(pix_ce),
    .DrawX(s_x), .DrawY(s_y), .hs(s_hs), .vs(s_vs), .blank(s_blank),
    .sof(s_sof), .eol(s_eol), .frame_count(s_fc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // leaves reset released mid-cycle; the next edge is the first advance
  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int err, hs_err, bl_err, eol_err, hs_low, sof_cnt, vs_low, bl_cnt, eol_cnt;
    int n, ex, ey, bad_pulse;

    // ---- reset state before any clock edge
    #1 reset = 1'b1;
    #1;
    chk("rst_x", d_x, 0);
    chk("rst_y", d_y, 0);
    chk("rst_hs", d_hs, 1);
    chk("rst_vs", d_vs, 1);
    chk("rst_blank", d_blank, 1);
    chk("rst_sof", d_sof, 0);
    chk("rst_eol", d_eol, 0);
    chk("rst_fc", d_fc, 0);

    // ---- default timing, two lines
    pix_ce = 1'b1;
    do_reset();
    err = 0; hs_err = 0; bl_err = 0; eol_err = 0; hs_low = 0; sof_cnt = 0;
    for (int k = 1; k <= 1600; k++) begin
      tick();
      ex = k % 800;
      ey = k / 800;
      if (d_x !== 10'(ex) || d_y !== 10'(ey)) err++;
      if (d_hs !== !(ex >= 656 && ex < 752)) hs_err++;
      if (d_blank !== (ex < 640 && ey < 480)) bl_err++;
      if (d_eol !== (ex == 799)) eol_err++;
      if (!d_hs) hs_low++;
      if (d_sof) sof_cnt++;
      if (k == 1) chk("dflt_first_x", d_x, 1);
      if (k == 799) begin
        chk("dflt_x799", d_x, 799);
        chk("dflt_eol799", d_eol, 1);
      end
      if (k == 800) begin
        chk("dflt_wrap_x", d_x, 0);
        chk("dflt_wrap_y", d_y, 1);
      end
    end
    chk("dflt_pos_err", err, 0);
    chk("dflt_hs_err", hs_err, 0);
    chk("dflt_hs_low", hs_low, 192);
    chk("dflt_blank_err", bl_err, 0);
    chk("dflt_eol_err", eol_err, 0);
    chk("dflt_no_sof", sof_cnt, 0);

    // ---- small timing, one full frame plus the (14,7)->(0,0) boundary
    do_reset();
    sof_cnt = 0; vs_low = 0; bl_cnt = 0; eol_cnt = 0; hs_low = 0;
    for (int k = 1; k <= 120; k++) begin
      tick();
      if (s_sof) begin
        sof_cnt++;
        chk("sof_at_x0", s_x, 0);
        chk("sof_at_y0", s_y, 0);
      end
      if (!s_vs) vs_low++;
      if (!s_hs) hs_low++;
      if (s_blank) bl_cnt++;
      if (s_eol) eol_cnt++;
      if (k == 119) begin
        chk("bnd_x", s_x, 14);
        chk("bnd_y", s_y, 7);
        chk("bnd_eol", s_eol, 1);
        chk("bnd_sof", s_sof, 0);
        chk("bnd_blank", s_blank, 0);
        chk("bnd_vs", s_vs, 1);
        chk("bnd_fc", s_fc, 0);
      end
      if (k == 120) begin
        chk("wrap_eol", s_eol, 0);
        chk("wrap_sof", s_sof, 1);
        chk("wrap_blank", s_blank, 1);
        chk("wrap_vs", s_vs, 1);
        chk("wrap_fc", s_fc, 1);
      end
    end
    chk("frm_sof_cnt", sof_cnt, 1);
    chk("frm_vs_low", vs_low, 30);
    chk("frm_hs_low", hs_low, 24);
    chk("frm_blank_cnt", bl_cnt, 32);
    chk("frm_eol_cnt", eol_cnt, 8);

    // ---- pix_ce toggling 1,0,1,0: one frame over 240 cycles
    do_reset();
    n = 0; err = 0; bad_pulse = 0; sof_cnt = 0;
    for (int k = 1; k <= 240; k++) begin
      pix_ce = (k % 2 == 1);
      tick();
      if (pix_ce) n++;
      ex = n % 15;
      ey = (n / 15) % 8;
      if (s_x !== 10'(ex) || s_y !== 10'(ey)) err++;
      if (!pix_ce && (s_sof || s_eol)) bad_pulse++;
      if (s_sof) sof_cnt++;
      if (k == 238) chk("tog_fc_before", s_fc, 0);
      if (k == 239) begin
        chk("tog_sof", s_sof, 1);
        chk("tog_fc_after", s_fc, 1);
      end
      if (k == 240) chk("tog_hold_fc", s_fc, 1);
    end
    pix_ce = 1'b1;
    chk("tog_pos_err", err, 0);
    chk("tog_bad_pulse", bad_pulse, 0);
    chk("tog_sof_cnt", sof_cnt, 1);

    // ---- 256 frames: frame_count wraps 255 -> 0
    do_reset();
    sof_cnt = 0;
    for (int k = 1; k <= 256 * 120; k++) begin
      tick();
      if (s_sof) sof_cnt++;
      if (k == 255 * 120) chk("fc_255", s_fc, 255);
    end
    chk("fc_wrap_sof", s_sof, 1);
    chk("fc_wrap_0", s_fc, 0);
    chk("fc_sof_cnt", sof_cnt, 256);

    // ---- async reset in the middle of hs/vs sync
    do_reset();
    repeat (221) tick();
    chk("mid_x", s_x, 11);
    chk("mid_y", s_y, 6);
    chk("mid_hs", s_hs, 0);
    chk("mid_vs", s_vs, 0);
    chk("mid_fc", s_fc, 1);
    #3 reset = 1'b1;
    #1;
    chk("arst_x", s_x, 0);
    chk("arst_y", s_y, 0);
    chk("arst_hs", s_hs, 1);
    chk("arst_vs", s_vs, 1);
    chk("arst_blank", s_blank, 1);
    chk("arst_sof", s_sof, 0);
    chk("arst_eol", s_eol, 0);
    chk("arst_fc", s_fc, 0);
    tick();
    tick();
    chk("rst_dominates_ce", s_x, 0);
    reset = 1'b0;
    tick();
    chk("post_first_x", s_x, 1);
    chk("post_first_y", s_y, 0);
    chk("post_no_sof", s_sof, 0);
    repeat (118) tick();
    chk("post_fc_119", s_fc, 0);
    tick();
    chk("post_sof_120", s_sof, 1);
    chk("post_fc_120", s_fc, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
